a2_bridge_arbiter: RTL and testbench
====================================

Name: a2_bridge_arbiter

Overview:
- Sequences and shares the A2N20v2 multiplexed 8-bit bridge port between up to NUM_REQ internal requesters.
- Bridge signals: 3-bit select, rd_n, wr_n, bidirectional data.
- Each granted request runs as one bridge read or write with a fixed strobe sequence.
- When no request is active, the block parks on the control-line group and samples it continuously.
- Sits between the bus sampler / GPIO / config logic and the FPGA bridge pins.

Parameters:
NUM_REQ, 3, number of requesters (1..8); index 0 has highest priority.
RD_SETUP_CYCLES, 1, cycles sel is stable with rd_n low before d_i is sampled (>=1).
WR_SETUP_CYCLES, 1, cycles data is driven with wr_n high before the strobe (>=1).
WR_PULSE_CYCLES, 1, cycles wr_n is held low (>=1).
IDLE_SEL, 3'd0, select value parked on while idle.

Ports:
clk_logic_i  in  1  logic clock
device_reset_n_i  in  1  synchronous active-low reset
req_valid_i  in  NUM_REQ  request pending, per requester
req_write_i  in  NUM_REQ  1 = write, 0 = read
req_sel_i  in  3*NUM_REQ  bridge select per requester; requester k uses bits [3k+2:3k]
req_wdata_i  in  8*NUM_REQ  write data per requester; requester k uses bits [8k+7:8k]
req_ready_o  out  NUM_REQ  grant / accept strobe (combinational)
rsp_valid_o  out  NUM_REQ  one-cycle completion pulse to the owning requester
rsp_rdata_o  out  8  read data; valid while rsp_valid_o is high for a read
idle_data_o  out  8  last control-group sample
idle_data_valid_o  out  1  one-cycle pulse on each new idle sample
busy_o  out  1  high when not in IDLE
a2_bridge_sel_o  out  3  bridge select
a2_bridge_rd_n_o  out  1  bridge read strobe, active low
a2_bridge_wr_n_o  out  1  bridge write strobe, active low
a2_bridge_d_o  out  8  bridge write data
a2_bridge_d_oe_o  out  1  bridge data output enable
a2_bridge_d_i  in  8  bridge read data

Behaviour:
- All bridge outputs are registered.
- States: IDLE, RD_SETUP, WR_SETUP, WR_PULSE, WR_HOLD. A 3-bit-minimum down-counter times multi-cycle states.
- Reset (sync, any state including mid-transaction), values at the next edge:
  - sel=IDLE_SEL, rd_n=1, wr_n=1, d_o=0, d_oe=0
  - rsp_valid=0, rsp_rdata=0, idle_data_o=8'hFF, idle_data_valid=0
  - state IDLE; the in-flight transaction is dropped with no rsp.
- IDLE:
  - Bridge outputs: sel=IDLE_SEL, rd_n=0, wr_n=1, d_oe=0.
  - idle_data_o<=d_i and idle_data_valid_o pulses only if the previous cycle was also IDLE. The first IDLE cycle after reset or after a transaction is a settle cycle with no sample.
- Arbitration, in IDLE only:
  - The lowest-index asserted req_valid_i wins; req_ready_o[k] is high that same cycle.
  - On the handshake, capture k, write, sel and wdata, then go to RD_SETUP or WR_SETUP.
  - Idle sampling still occurs on the handshake cycle.
- Handshake rules: req_valid_i stays high and its payload stable until ready. Fixed priority; no starvation guarantee.
- Read sequence:
  - RD_SETUP for RD_SETUP_CYCLES: sel=captured, rd_n=0, wr_n=1, d_oe=0.
  - At its last edge: rsp_rdata_o<=d_i, rsp_valid_o[k]<=1, next state IDLE.
  - Latency: handshake at T0, rsp_valid at T0+RD_SETUP_CYCLES+1.
- Write sequence:
  - WR_SETUP for WR_SETUP_CYCLES: sel=captured, d_o=wdata, d_oe=1, rd_n=1, wr_n=1.
  - WR_PULSE for WR_PULSE_CYCLES: wr_n=0, others held.
  - WR_HOLD for 1 cycle: wr_n=1, d_o/d_oe held.
  - Then IDLE with d_oe=0 and rsp_valid_o[k] pulsing in the first IDLE cycle.
  - With defaults the write occupies 3 cycles.
- Minimum one IDLE cycle between transactions.
- A request arriving in the cycle the block re-enters IDLE is granted that cycle.
- rd_n and wr_n are never both low. d_oe is never high while rd_n is low.
- rsp_rdata_o holds its value between reads.

Test Plan:
1. Reset, no requests -> idle outputs sel=0/rd_n=0/wr_n=1/oe=0; d_i=8'hA5 -> idle_data_o=8'hA5 with a valid pulse each cycle from the 2nd idle cycle onward.
2. Req1 read sel=2, d_i=8'h3C -> ready pulse at T0, sel=2/rd_n=0 at T1, rsp_valid[1]=1 with rdata=8'h3C at T2.
3. Req2 write sel=1 data 8'h5A -> T1 oe=1/d_o=5A/wr_n=1, T2 wr_n=0, T3 wr_n=1/oe=1, T4 oe=0 and rsp_valid[2]=1.
4. Req0 and req2 valid together -> req0 granted first; req2 granted in the IDLE cycle after req0 completes; no idle sample on that first IDLE cycle.
5. Reset asserted during WR_PULSE -> next edge wr_n=1, oe=0, sel=0; no rsp_valid; pending requests regranted after reset.
6. RD_SETUP_CYCLES=3, WR_PULSE_CYCLES=2 -> rsp_valid at T0+4; wr_n low exactly 2 cycles; assertions that rd_n and wr_n are never both low and oe is never high with rd_n low throughout.

Source files
------------

// File: rtl/a2_bridge_arbiter_if.sv
// Requester handshake, response, idle-sample and bridge-pin bundle for a2_bridge_arbiter.
// slave: the arbiter itself; master: requesters plus the bridge pad side.
// Widths track NUM_REQ; requester k owns sel bits [3k+2:3k] and wdata bits [8k+7:8k].
interface a2_bridge_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [NUM_REQ-1:0]   req_write_i;
  logic [3*NUM_REQ-1:0] req_sel_i;
  logic [8*NUM_REQ-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic [NUM_REQ-1:0]   rsp_valid_o;
  logic [7:0]           rsp_rdata_o;
  logic [7:0]           idle_data_o;
  logic                 idle_data_valid_o;
  logic                 busy_o;
  logic [2:0]           a2_bridge_sel_o;
  logic                 a2_bridge_rd_n_o;
  logic                 a2_bridge_wr_n_o;
  logic [7:0]           a2_bridge_d_o;
  logic                 a2_bridge_d_oe_o;
  logic [7:0]           a2_bridge_d_i;

  modport slave (
    input  req_valid_i, req_write_i, req_sel_i, req_wdata_i, a2_bridge_d_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, idle_data_o, idle_data_valid_o,
           busy_o, a2_bridge_sel_o, a2_bridge_rd_n_o, a2_bridge_wr_n_o,
           a2_bridge_d_o, a2_bridge_d_oe_o
  );

  modport master (
    output req_valid_i, req_write_i, req_sel_i, req_wdata_i, a2_bridge_d_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, idle_data_o, idle_data_valid_o,
           busy_o, a2_bridge_sel_o, a2_bridge_rd_n_o, a2_bridge_wr_n_o,
           a2_bridge_d_o, a2_bridge_d_oe_o
  );
endinterface

// File: rtl/a2_bridge_arbiter.sv
// Fixed-priority sharer of the A2N20v2 8-bit bridge port; parks on IDLE_SEL and samples it when idle.
// Latency: read rsp at grant+RD_SETUP_CYCLES+1, write rsp at grant+WR_SETUP+WR_PULSE+2; all bridge pins registered.
// Backpressure: req_ready_o only in IDLE (and out of reset); requesters hold valid and payload until ready.
module a2_bridge_arbiter #(
  parameter int         NUM_REQ         = 3,
  parameter int         RD_SETUP_CYCLES = 1,
  parameter int         WR_SETUP_CYCLES = 1,
  parameter int         WR_PULSE_CYCLES = 1,
  parameter logic [2:0] IDLE_SEL        = 3'd0
) (
  input  logic                clk_logic_i,
  input  logic                device_reset_n_i,
  a2_bridge_arbiter_if.slave  bus
);

  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAX_RW  = (RD_SETUP_CYCLES > WR_SETUP_CYCLES) ? RD_SETUP_CYCLES : WR_SETUP_CYCLES;
  localparam int MAX_CYC = (MAX_RW > WR_PULSE_CYCLES) ? MAX_RW : WR_PULSE_CYCLES;
  localparam int CW      = ($clog2(MAX_CYC) > 3) ? $clog2(MAX_CYC) : 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_SETUP,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic                r_prev_idle;
  logic [2:0]          r_sel;
  logic                r_rd_n;
  logic                r_wr_n;
  logic [7:0]          r_d_o;
  logic                r_d_oe;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [7:0]          r_rsp_rdata;
  logic [7:0]          r_idle_data;
  logic                r_idle_vld;

  logic                w_any;
  logic [IW-1:0]       w_idx;
  logic                w_write;
  logic [2:0]          w_sel;
  logic [7:0]          w_wdata;
  logic [NUM_REQ-1:0]  w_grant;

  // Pick the lowest-index pending requester; scanning downward lets the lowest index win.
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid_i[k]) begin
        w_any = 1'b1;
        w_idx = IW'(k);
      end
    end
  end

  assign w_write = bus.req_write_i[w_idx];
  assign w_sel   = bus.req_sel_i[3*int'(w_idx) +: 3];
  assign w_wdata = bus.req_wdata_i[8*int'(w_idx) +: 8];

  // Ready is withheld during reset so a handshake can never be lost to the reset edge.
  assign w_grant = (r_state == ST_IDLE && device_reset_n_i && w_any) ? (NUM_REQ'(1) << w_idx) : '0;

  // Sequencer: state, timing counter and every registered bridge/response output.
  always_ff @(posedge clk_logic_i) begin
    if (!device_reset_n_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_prev_idle <= 1'b0;
      r_sel       <= IDLE_SEL;
      r_rd_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_d_o       <= 8'h00;
      r_d_oe      <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= 8'h00;
      r_idle_data <= 8'hFF;
      r_idle_vld  <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      r_idle_vld  <= 1'b0;
      r_prev_idle <= (r_state == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          // The first idle cycle only lets the parked select settle; sample from the second on.
          if (r_prev_idle) begin
            r_idle_data <= bus.a2_bridge_d_i;
            r_idle_vld  <= 1'b1;
          end
          if (w_any) begin
            r_idx <= w_idx;
            r_sel <= w_sel;
            if (w_write) begin
              r_state <= ST_WR_SETUP;
              r_cnt   <= CW'(WR_SETUP_CYCLES - 1);
              r_d_o   <= w_wdata;
              r_d_oe  <= 1'b1;
              r_rd_n  <= 1'b1;
              r_wr_n  <= 1'b1;
            end else begin
              r_state <= ST_RD_SETUP;
              r_cnt   <= CW'(RD_SETUP_CYCLES - 1);
              r_d_oe  <= 1'b0;
              r_rd_n  <= 1'b0;
              r_wr_n  <= 1'b1;
            end
          end else begin
            r_sel  <= IDLE_SEL;
            r_rd_n <= 1'b0;
            r_wr_n <= 1'b1;
            r_d_oe <= 1'b0;
          end
        end
        ST_RD_SETUP: begin
          if (r_cnt == '0) begin
            r_rsp_rdata <= bus.a2_bridge_d_i;
            r_rsp_valid <= NUM_REQ'(1) << r_idx;
            r_state     <= ST_IDLE;
            r_sel       <= IDLE_SEL;
            r_rd_n      <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_WR_SETUP: begin
          if (r_cnt == '0) begin
            r_state <= ST_WR_PULSE;
            r_cnt   <= CW'(WR_PULSE_CYCLES - 1);
            r_wr_n  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_WR_PULSE: begin
          if (r_cnt == '0) begin
            r_state <= ST_WR_HOLD;
            r_wr_n  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_WR_HOLD: begin
          // Release the bus and return to parking; rd_n and oe change on the same edge.
          r_state     <= ST_IDLE;
          r_rsp_valid <= NUM_REQ'(1) << r_idx;
          r_d_oe      <= 1'b0;
          r_sel       <= IDLE_SEL;
          r_rd_n      <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o       = w_grant;
  assign bus.rsp_valid_o       = r_rsp_valid;
  assign bus.rsp_rdata_o       = r_rsp_rdata;
  assign bus.idle_data_o       = r_idle_data;
  assign bus.idle_data_valid_o = r_idle_vld;
  assign bus.busy_o            = (r_state != ST_IDLE);
  assign bus.a2_bridge_sel_o   = r_sel;
  assign bus.a2_bridge_rd_n_o  = r_rd_n;
  assign bus.a2_bridge_wr_n_o  = r_wr_n;
  assign bus.a2_bridge_d_o     = r_d_o;
  assign bus.a2_bridge_d_oe_o  = r_d_oe;

endmodule

// File: tb/tb_a2_bridge_arbiter.sv
// Bench for a2_bridge_arbiter: default-parameter instance A, stretched-timing instance B.
// Table of single transactions plus hand sequences on A; directed and random traffic on B.
// Random traffic is checked against a transaction-level model (grant order, latency, data, idle sampling).
module tb_a2_bridge_arbiter;
  localparam int N    = 3;
  localparam int RD_B = 3;
  localparam int WS_B = 1;
  localparam int WP_B = 2;
  localparam int NCYC = 800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;
  logic [N-1:0]   a_vld, a_wr, b_vld, b_wr;
  logic [3*N-1:0] a_sel, b_sel;
  logic [8*N-1:0] a_wd, b_wd;
  logic [7:0]     a_din, b_din;

  a2_bridge_arbiter_if #(.NUM_REQ(N)) ba ();
  a2_bridge_arbiter_if #(.NUM_REQ(N)) bb ();

  assign ba.req_valid_i = a_vld;
  assign ba.req_write_i = a_wr;
  assign ba.req_sel_i = a_sel;
  assign ba.req_wdata_i = a_wd;
  assign ba.a2_bridge_d_i = a_din;
  assign bb.req_valid_i = b_vld;
  assign bb.req_write_i = b_wr;
  assign bb.req_sel_i = b_sel;
  assign bb.req_wdata_i = b_wd;
  assign bb.a2_bridge_d_i = b_din;

  a2_bridge_arbiter #(.NUM_REQ(N)) dut_a (
    .clk_logic_i(clk), .device_reset_n_i(rst_a_n), .bus(ba.slave));
  a2_bridge_arbiter #(.NUM_REQ(N), .RD_SETUP_CYCLES(RD_B), .WR_SETUP_CYCLES(WS_B),
                      .WR_PULSE_CYCLES(WP_B)) dut_b (
    .clk_logic_i(clk), .device_reset_n_i(rst_b_n), .bus(bb.slave));

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic a_req(input int k, input logic wr, input logic [2:0] s, input logic [7:0] d);
    a_vld[k] = 1'b1; a_wr[k] = wr; a_sel[3*k +: 3] = s; a_wd[8*k +: 8] = d;
  endtask

  task automatic b_req(input int k, input logic wr, input logic [2:0] s, input logic [7:0] d);
    b_vld[k] = 1'b1; b_wr[k] = wr; b_sel[3*k +: 3] = s; b_wd[8*k +: 8] = d;
  endtask

  function automatic logic [N-1:0] lowest(input logic [N-1:0] p);
    for (int k = 0; k < N; k++) if (p[k]) return N'(1) << k;
    return '0;
  endfunction

  // Strobe-safety invariants on both instances, every cycle.
  always @(negedge clk) begin
    #2;
    chk("inv_a", ((ba.a2_bridge_rd_n_o === 1'b0 && ba.a2_bridge_wr_n_o === 1'b0) ||
                  (ba.a2_bridge_d_oe_o === 1'b1 && ba.a2_bridge_rd_n_o === 1'b0)) ? 1 : 0, 0);
    chk("inv_b", ((bb.a2_bridge_rd_n_o === 1'b0 && bb.a2_bridge_wr_n_o === 1'b0) ||
                  (bb.a2_bridge_d_oe_o === 1'b1 && bb.a2_bridge_rd_n_o === 1'b0)) ? 1 : 0, 0);
  end

  typedef struct {
    int         idx;
    logic       wr;
    logic [2:0] sel;
    logic [7:0] wd;
    logic [7:0] din;
    logic [2:0] exp_rdy;
    int         exp_lat;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t tbl [6];

  // random-phase model state
  logic [N-1:0] pend;
  logic         o_act, o_wr, p1, p2, exp_vld, exp_busy;
  int           o_idx, o_due, o_samp, o_low, lowc;
  logic [2:0]   o_sel;
  logic [7:0]   o_wd, o_rd, hold_rd, din_prev;
  logic [N-1:0] exp_rdy;

  initial begin
    a_vld = '0; a_wr = '0; a_sel = '0; a_wd = '0; a_din = 8'h00;
    b_vld = '0; b_wr = '0; b_sel = '0; b_wd = '0; b_din = 8'h00;
    rst_a_n = 1'b0; rst_b_n = 1'b0;

    tbl[0] = '{1, 1'b0, 3'd2, 8'h00, 8'h3C, 3'b010, 2, 8'h3C};
    tbl[1] = '{2, 1'b1, 3'd1, 8'h5A, 8'h00, 3'b100, 4, 8'h3C};
    tbl[2] = '{0, 1'b0, 3'd7, 8'h00, 8'hC3, 3'b001, 2, 8'hC3};
    tbl[3] = '{0, 1'b1, 3'd4, 8'hFF, 8'h11, 3'b001, 4, 8'hC3};
    tbl[4] = '{1, 1'b1, 3'd6, 8'h81, 8'h22, 3'b010, 4, 8'hC3};
    tbl[5] = '{2, 1'b0, 3'd5, 8'h00, 8'h96, 3'b100, 2, 8'h96};

    // ---- reset state and idle sampling (instance A)
    a_din = 8'hA5;
    step(); step();
    chk("rst_sel", ba.a2_bridge_sel_o, 3'd0);
    chk("rst_rd_n", ba.a2_bridge_rd_n_o, 1'b1);
    chk("rst_wr_n", ba.a2_bridge_wr_n_o, 1'b1);
    chk("rst_d_o", ba.a2_bridge_d_o, 8'h00);
    chk("rst_oe", ba.a2_bridge_d_oe_o, 1'b0);
    chk("rst_rsp", ba.rsp_valid_o, 3'b000);
    chk("rst_rdata", ba.rsp_rdata_o, 8'h00);
    chk("rst_idata", ba.idle_data_o, 8'hFF);
    chk("rst_ivld", ba.idle_data_valid_o, 1'b0);
    chk("rst_busy", ba.busy_o, 1'b0);
    rst_a_n = 1'b1;
    step();
    chk("idle1_rd_n", ba.a2_bridge_rd_n_o, 1'b0);
    chk("idle1_sel", ba.a2_bridge_sel_o, 3'd0);
    chk("idle1_wr_n", ba.a2_bridge_wr_n_o, 1'b1);
    chk("idle1_oe", ba.a2_bridge_d_oe_o, 1'b0);
    chk("idle1_ivld", ba.idle_data_valid_o, 1'b0);
    step();
    chk("idle2_ivld", ba.idle_data_valid_o, 1'b1);
    chk("idle2_idata", ba.idle_data_o, 8'hA5);
    a_din = 8'h5C;
    step();
    chk("idle3_ivld", ba.idle_data_valid_o, 1'b1);
    chk("idle3_idata", ba.idle_data_o, 8'h5C);

    // ---- table of single transactions (instance A)
    for (int i = 0; i < 6; i++) begin
      step();
      a_req(tbl[i].idx, tbl[i].wr, tbl[i].sel, tbl[i].wd);
      a_din = tbl[i].din;
      #1;
      chk("tbl_rdy", ba.req_ready_o, tbl[i].exp_rdy);
      step();
      a_vld[tbl[i].idx] = 1'b0;
      chk("tbl_t1_sel", ba.a2_bridge_sel_o, tbl[i].sel);
      chk("tbl_t1_busy", ba.busy_o, 1'b1);
      chk("tbl_t1_oe", ba.a2_bridge_d_oe_o, tbl[i].wr);
      chk("tbl_t1_rd_n", ba.a2_bridge_rd_n_o, tbl[i].wr);
      chk("tbl_t1_wr_n", ba.a2_bridge_wr_n_o, 1'b1);
      if (tbl[i].wr) chk("tbl_t1_d_o", ba.a2_bridge_d_o, tbl[i].wd);
      for (int t = 2; t <= tbl[i].exp_lat; t++) begin
        step();
        if (tbl[i].wr && t == 2) chk("tbl_t2_wr_n", ba.a2_bridge_wr_n_o, 1'b0);
        if (tbl[i].wr && t == 3) begin
          chk("tbl_t3_wr_n", ba.a2_bridge_wr_n_o, 1'b1);
          chk("tbl_t3_oe", ba.a2_bridge_d_oe_o, 1'b1);
        end
        chk("tbl_rsp", ba.rsp_valid_o, (t == tbl[i].exp_lat) ? tbl[i].exp_rdy : 3'b000);
      end
      chk("tbl_end_oe", ba.a2_bridge_d_oe_o, 1'b0);
      chk("tbl_rdata", ba.rsp_rdata_o, tbl[i].exp_rdata);
    end

    // ---- simultaneous requests: priority and back-to-back grant (instance A)
    step();
    a_req(0, 1'b0, 3'd3, 8'h00);
    a_req(2, 1'b1, 3'd1, 8'h77);
    a_din = 8'h44;
    #1;
    chk("pri_rdy0", ba.req_ready_o, 3'b001);
    step();
    a_vld[0] = 1'b0;
    chk("pri_t1_rdy", ba.req_ready_o, 3'b000);
    step();
    chk("pri_t2_rsp", ba.rsp_valid_o, 3'b001);
    chk("pri_t2_rdata", ba.rsp_rdata_o, 8'h44);
    chk("pri_t2_rdy", ba.req_ready_o, 3'b100);
    chk("pri_t2_ivld", ba.idle_data_valid_o, 1'b0);
    step();
    a_vld[2] = 1'b0;
    chk("pri_t3_ivld", ba.idle_data_valid_o, 1'b0);
    chk("pri_t3_oe", ba.a2_bridge_d_oe_o, 1'b1);
    chk("pri_t3_d_o", ba.a2_bridge_d_o, 8'h77);
    step(); step(); step();
    chk("pri_t6_rsp", ba.rsp_valid_o, 3'b100);
    step();
    chk("pri_t7_ivld", ba.idle_data_valid_o, 1'b0);
    step();
    chk("pri_t8_ivld", ba.idle_data_valid_o, 1'b1);
    chk("pri_t8_idata", ba.idle_data_o, 8'h44);

    // ---- reset in the middle of a write pulse (instance A)
    step();
    a_req(1, 1'b1, 3'd5, 8'hE7);
    #1;
    chk("mr_rdy", ba.req_ready_o, 3'b010);
    step();
    a_vld[1] = 1'b0;
    a_req(0, 1'b0, 3'd3, 8'h00);
    a_din = 8'h9B;
    step();
    chk("mr_pulse", ba.a2_bridge_wr_n_o, 1'b0);
    rst_a_n = 1'b0;
    step();
    chk("mr_wr_n", ba.a2_bridge_wr_n_o, 1'b1);
    chk("mr_oe", ba.a2_bridge_d_oe_o, 1'b0);
    chk("mr_sel", ba.a2_bridge_sel_o, 3'd0);
    chk("mr_rsp", ba.rsp_valid_o, 3'b000);
    chk("mr_busy", ba.busy_o, 1'b0);
    rst_a_n = 1'b1;
    #1;
    chk("mr_regrant", ba.req_ready_o, 3'b001);
    step();
    a_vld[0] = 1'b0;
    chk("mr_rd_sel", ba.a2_bridge_sel_o, 3'd3);
    chk("mr_rd_rsp", ba.rsp_valid_o, 3'b000);
    step();
    chk("mr_rd_done", ba.rsp_valid_o, 3'b001);
    chk("mr_rd_data", ba.rsp_rdata_o, 8'h9B);

    // ---- stretched timing (instance B): read latency 4, write pulse 2 cycles
    rst_b_n = 1'b1;
    step(); step();
    b_req(0, 1'b0, 3'd6, 8'h00);
    b_din = 8'h5D;
    #1;
    chk("b_rd_rdy", bb.req_ready_o, 3'b001);
    step();
    b_vld[0] = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      if (t > 1) step();
      if (t < 4) begin
        chk("b_rd_rd_n", bb.a2_bridge_rd_n_o, 1'b0);
        chk("b_rd_sel", bb.a2_bridge_sel_o, 3'd6);
        chk("b_rd_rsp0", bb.rsp_valid_o, 3'b000);
      end else begin
        chk("b_rd_rsp", bb.rsp_valid_o, 3'b001);
        chk("b_rd_data", bb.rsp_rdata_o, 8'h5D);
      end
    end
    step();
    b_req(1, 1'b1, 3'd2, 8'hB4);
    #1;
    chk("b_wr_rdy", bb.req_ready_o, 3'b010);
    lowc = 0;
    for (int t = 1; t <= 5; t++) begin
      step();
      if (t == 1) begin
        b_vld[1] = 1'b0;
        chk("b_wr_d_o", bb.a2_bridge_d_o, 8'hB4);
      end
      if (bb.a2_bridge_wr_n_o === 1'b0) lowc++;
      chk("b_wr_rsp", bb.rsp_valid_o, (t == 5) ? 3'b010 : 3'b000);
    end
    chk("b_wr_low", lowc, WP_B);

    // ---- random traffic on B against a transaction-level model
    rst_b_n = 1'b0;
    step(); step();
    rst_b_n = 1'b1;
    pend = '0; o_act = 1'b0; o_wr = 1'b0; o_idx = 0; o_due = 0; o_samp = 0; o_low = 0;
    o_sel = 3'd0; o_wd = 8'h00; o_rd = 8'h00; hold_rd = 8'h00;
    p1 = 1'b1; p2 = 1'b0; din_prev = b_din;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      b_din = 8'($urandom_range(255));
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && c < NCYC - 60 && $urandom_range(3) == 0) begin
          pend[k] = 1'b1;
          b_req(k, 1'($urandom_range(1)), 3'($urandom_range(7)), 8'($urandom_range(255)));
        end
      end
      b_vld = pend;
      #1;
      if (o_act && c == o_due) begin
        chk("r_rsp", bb.rsp_valid_o, N'(1) << o_idx);
        if (!o_wr) hold_rd = o_rd;
        else chk("r_wr_low", o_low, WP_B);
        o_act = 1'b0;
      end else begin
        chk("r_rsp0", bb.rsp_valid_o, '0);
      end
      chk("r_rdata", bb.rsp_rdata_o, hold_rd);
      exp_busy = o_act;
      chk("r_busy", bb.busy_o, exp_busy);
      if (o_act) begin
        chk("r_sel", bb.a2_bridge_sel_o, o_sel);
        chk("r_oe", bb.a2_bridge_d_oe_o, o_wr);
        chk("r_rd_n", bb.a2_bridge_rd_n_o, o_wr);
        if (o_wr) chk("r_d_o", bb.a2_bridge_d_o, o_wd);
        if (c == o_samp) o_rd = b_din;
        if (bb.a2_bridge_wr_n_o === 1'b0) o_low++;
      end else begin
        chk("r_idle_sel", bb.a2_bridge_sel_o, 3'd0);
        chk("r_idle_rd_n", bb.a2_bridge_rd_n_o, 1'b0);
        chk("r_idle_wr_n", bb.a2_bridge_wr_n_o, 1'b1);
        chk("r_idle_oe", bb.a2_bridge_d_oe_o, 1'b0);
      end
      exp_vld = p1 && p2;
      chk("r_ivld", bb.idle_data_valid_o, exp_vld);
      if (exp_vld) chk("r_idata", bb.idle_data_o, din_prev);
      exp_rdy = o_act ? '0 : lowest(pend);
      chk("r_rdy", bb.req_ready_o, exp_rdy);
      if (exp_rdy != '0) begin
        for (int k = 0; k < N; k++) if (exp_rdy[k]) o_idx = k;
        o_act = 1'b1;
        o_wr  = b_wr[o_idx];
        o_sel = b_sel[3*o_idx +: 3];
        o_wd  = b_wd[8*o_idx +: 8];
        o_due = c + (o_wr ? (WS_B + WP_B + 2) : (RD_B + 1));
        o_samp = c + RD_B;
        o_low = 0;
        pend[o_idx] = 1'b0;
      end
      p2 = p1;
      p1 = !exp_busy;
      din_prev = b_din;
    end
    chk("r_drain_pend", pend, '0);
    chk("r_drain_act", o_act, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
